// File: rtl/root_bit.sv
`default_nettype none
// ============================================================================
// Module      : root_bit
// Description : Iterative integer k-th root extractor. Finds the largest
//               ROOT_W-bit r with r^pow <= value by a bit-serial binary
//               search over the root bits, recomputing each candidate power
//               with one multiply per clock. Flags exact roots and pow==0.
// Revision    : 1.0 - initial release
// ============================================================================
module root_bit #(
  parameter int VAL_W  = 16,
  parameter int ROOT_W = 5,
  parameter int POW_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [VAL_W-1:0]  value,
  input  logic [POW_W-1:0]  pow,
  output logic [ROOT_W-1:0] root,
  output logic              exact,
  output logic              err,
  output logic              busy,
  output logic              done
);

  // Full product width: a VAL_W power times a ROOT_W candidate never loses bits.
  localparam int c_PROD_W = VAL_W + ROOT_W;
  localparam int c_BIT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [c_BIT_W-1:0] c_TOP_BIT = c_BIT_W'(ROOT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched operands
  logic [VAL_W-1:0]   r_value;
  logic [POW_W-1:0]   r_pow;

  // Search state
  logic [c_BIT_W-1:0] r_bit;
  logic [ROOT_W-1:0]  r_acc;
  logic [ROOT_W-1:0]  r_cand;
  logic [VAL_W-1:0]   r_p;
  logic               r_sat;
  logic [POW_W-1:0]   r_cnt;
  logic               r_exact_acc;

  // Result registers
  logic [ROOT_W-1:0]  r_root;
  logic               r_exact;
  logic               r_err;
  logic               r_busy;
  logic               r_done;

  // Datapath helpers
  logic [c_PROD_W-1:0] w_prod;
  logic                w_ovf;
  logic                w_keep;
  logic                w_eq;
  logic [ROOT_W-1:0]   w_acc_fin;
  logic                w_exact_fin;
  logic [c_BIT_W-1:0]  w_bit_dec;
  logic [ROOT_W-1:0]  w_bit_mask;
  logic [ROOT_W-1:0]  w_cand_nxt;
  logic [ROOT_W-1:0]  w_top_mask;

  // One candidate-power multiply step; any bit above VAL_W means overflow.
  always_comb begin
    w_prod = c_PROD_W'(r_p) * c_PROD_W'(r_cand);
    w_ovf  = |w_prod[c_PROD_W-1:VAL_W];
  end

  // Comparison of the finished power against the radicand and next candidate.
  always_comb begin
    // A saturated power exceeded the value range, so it can never be kept.
    w_keep      = !r_sat && (r_p <= r_value);
    w_eq        = (r_p == r_value);
    w_acc_fin   = w_keep ? r_cand : r_acc;
    w_exact_fin = w_keep ? w_eq : r_exact_acc;
    w_bit_dec   = r_bit - c_BIT_W'(1);
    w_bit_mask  = ROOT_W'(1) << w_bit_dec;
    w_cand_nxt  = w_acc_fin | w_bit_mask;
    w_top_mask  = ROOT_W'(1) << c_TOP_BIT;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (pow == '0) ? S_DONE : S_MUL;
        end
      end
      S_MUL: begin
        // The multiply issued with cnt==1 is the last one for this candidate.
        if (r_cnt == POW_W'(1)) begin
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        w_state_nxt = (r_bit == '0) ? S_DONE : S_MUL;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand latch, search datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value     <= '0;
      r_pow       <= '0;
      r_bit       <= '0;
      r_acc       <= '0;
      r_cand      <= '0;
      r_p         <= '0;
      r_sat       <= 1'b0;
      r_cnt       <= '0;
      r_exact_acc <= 1'b0;
      r_root      <= '0;
      r_exact     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (pow != '0) begin
              r_value     <= value;
              r_pow       <= pow;
              r_bit       <= c_TOP_BIT;
              r_acc       <= '0;
              r_cand      <= w_top_mask;
              r_p         <= VAL_W'(1);
              r_sat       <= 1'b0;
              r_cnt       <= pow;
              r_exact_acc <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              // A zeroth root is undefined: report it without searching.
              r_root  <= '0;
              r_exact <= 1'b0;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // Once saturated the power value is meaningless; the flag is sticky.
          r_p   <= w_prod[VAL_W-1:0];
          r_sat <= r_sat | w_ovf;
          r_cnt <= r_cnt - POW_W'(1);
        end
        S_CMP: begin
          if (w_keep) begin
            r_acc       <= r_cand;
            r_exact_acc <= w_eq;
          end
          if (r_bit == '0) begin
            r_root <= w_acc_fin;
            // value==0 keeps no candidate, yet 0^pow==0 is exact.
            r_exact <= w_exact_fin | (r_value == '0);
            r_err   <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_bit  <= w_bit_dec;
            r_cand <= w_cand_nxt;
            r_p    <= VAL_W'(1);
            r_sat  <= 1'b0;
            r_cnt  <= r_pow;
          end
        end
        S_DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign root  = r_root;
  assign exact = r_exact;
  assign err   = r_err;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire
